// File: rtl/sap1_ctrl_pkg.sv
// Shared constants for the SAP-1 control unit: opcodes, ring states and
// control-word bit positions.
package sap1_ctrl_pkg;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int NUM_T = 6;

  localparam logic [NUM_T-1:0] T1 = 6'b000001;
  localparam logic [NUM_T-1:0] T2 = 6'b000010;
  localparam logic [NUM_T-1:0] T3 = 6'b000100;
  localparam logic [NUM_T-1:0] T4 = 6'b001000;
  localparam logic [NUM_T-1:0] T5 = 6'b010000;
  localparam logic [NUM_T-1:0] T6 = 6'b100000;

  // Control word packs as {cp,ep,lm,ce,li,ei,la,ea,su,eu,lb,lo}, cp in the MSB.
  localparam int CTRL_W = 12;
  localparam int CP_B = 11;
  localparam int EP_B = 10;
  localparam int LM_B = 9;
  localparam int CE_B = 8;
  localparam int LI_B = 7;
  localparam int EI_B = 6;
  localparam int LA_B = 5;
  localparam int EA_B = 4;
  localparam int SU_B = 3;
  localparam int EU_B = 2;
  localparam int LB_B = 1;
  localparam int LO_B = 0;

  typedef logic [CTRL_W-1:0] ctrl_t;

endpackage

// File: rtl/t_ring_counter.sv
// One-hot rotate-left ring counter with synchronous active-low reset and
// an advance enable; the top bit wraps back into bit 0.
module t_ring_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         adv,
  output logic [W-1:0] t_state
);

  always_ff @(posedge clk) begin
    if (!reset)   t_state <= {{(W-1){1'b0}}, 1'b1};
    else if (adv) t_state <= {t_state[W-2:0], t_state[W-1]};
  end

endmodule

// File: rtl/controller_sequencer.sv
// SAP-1 control unit: drives the ring counter, holds the sticky halt flag and
// decodes the microcode control word from ring state and opcode.
module controller_sequencer
  import sap1_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       step_mode,
  input  logic       step,
  output logic [5:0] t_state,
  output logic       halted,
  output logic       cp,
  output logic       ep,
  output logic       lm,
  output logic       ce,
  output logic       li,
  output logic       ei,
  output logic       la,
  output logic       ea,
  output logic       su,
  output logic       eu,
  output logic       lb,
  output logic       lo
);

  logic  adv_req;
  logic  hlt_now;
  ctrl_t ctrl;

  assign adv_req = !halted && (!step_mode || step);
  // HLT consumes the T4 advance: the flag sets and the ring stays parked at T4.
  assign hlt_now = adv_req && (t_state == T4) && (opcode == OP_HLT);

  t_ring_counter #(.W(NUM_T)) u_ring (
    .clk     (clk),
    .reset   (reset),
    .adv     (adv_req && !hlt_now),
    .t_state (t_state)
  );

  always_ff @(posedge clk) begin
    if (!reset)       halted <= 1'b0;
    else if (hlt_now) halted <= 1'b1;
  end

  always_comb begin
    ctrl = '0;
    if (!halted) begin
      case (t_state)
        T1: begin ctrl[EP_B] = 1'b1; ctrl[LM_B] = 1'b1; end
        T2: ctrl[CP_B] = 1'b1;
        T3: begin ctrl[CE_B] = 1'b1; ctrl[LI_B] = 1'b1; end
        T4: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB: begin ctrl[EI_B] = 1'b1; ctrl[LM_B] = 1'b1; end
            OP_OUT:                 begin ctrl[EA_B] = 1'b1; ctrl[LO_B] = 1'b1; end
            default: ;
          endcase
        end
        T5: begin
          case (opcode)
            OP_LDA:         begin ctrl[CE_B] = 1'b1; ctrl[LA_B] = 1'b1; end
            OP_ADD, OP_SUB: begin ctrl[CE_B] = 1'b1; ctrl[LB_B] = 1'b1; end
            default: ;
          endcase
        end
        T6: begin
          case (opcode)
            OP_ADD: begin ctrl[EU_B] = 1'b1; ctrl[LA_B] = 1'b1; end
            OP_SUB: begin ctrl[EU_B] = 1'b1; ctrl[LA_B] = 1'b1; ctrl[SU_B] = 1'b1; end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo} = ctrl;

endmodule

// File: tb/tb_controller_sequencer.sv
// Bench for controller_sequencer: directed scenarios plus random traffic,
// checked against a step-index/instruction-table model of the sequencer.
module tb_controller_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic       step_mode = 1'b0;
  logic       step = 1'b0;
  logic [5:0] t_state;
  logic       halted;
  logic       cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo;

  controller_sequencer dut (
    .clk(clk), .reset(reset), .opcode(opcode), .step_mode(step_mode), .step(step),
    .t_state(t_state), .halted(halted),
    .cp(cp), .ep(ep), .lm(lm), .ce(ce), .li(li), .ei(ei),
    .la(la), .ea(ea), .su(su), .eu(eu), .lb(lb), .lo(lo)
  );

  always #5 clk = ~clk;

  localparam logic [11:0] CP = 12'h800, EP = 12'h400, LM = 12'h200, CE = 12'h100;
  localparam logic [11:0] LI = 12'h080, EI = 12'h040, LA = 12'h020, EA = 12'h010;
  localparam logic [11:0] SU = 12'h008, EU = 12'h004, LB = 12'h002, LO = 12'h001;

  int checks = 0;
  int failures = 0;

  // Model: which step (0 = T1 .. 5 = T6) the machine is in, and halt status.
  int m_idx = 0;
  bit m_halt = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] exp_ctrl(input int idx, input logic [3:0] op, input bit h);
    logic [11:0] c;
    c = '0;
    if (!h) begin
      case (idx)
        0: c = EP | LM;
        1: c = CP;
        2: c = CE | LI;
        3: c = (op == 4'h0 || op == 4'h1 || op == 4'h2) ? (EI | LM) :
               (op == 4'hE) ? (EA | LO) : 12'h000;
        4: c = (op == 4'h0) ? (CE | LA) :
               (op == 4'h1 || op == 4'h2) ? (CE | LB) : 12'h000;
        5: c = (op == 4'h1) ? (EU | LA) :
               (op == 4'h2) ? (EU | LA | SU) : 12'h000;
        default: c = '0;
      endcase
    end
    return c;
  endfunction

  // Apply inputs for one clock, check outputs mid-cycle, then step the model.
  task automatic cycle(input logic r, input logic sm, input logic st,
                       input logic [3:0] op, input string tag);
    logic [5:0] exp_t;
    reset = r; step_mode = sm; step = st; opcode = op;
    @(negedge clk);
    exp_t = 6'b000001 << m_idx;
    chk({tag, ".t_state"}, 32'(t_state), 32'(exp_t));
    chk({tag, ".halted"}, 32'(halted), 32'(m_halt));
    chk({tag, ".ctrl"}, 32'({cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo}),
        32'(exp_ctrl(m_idx, op, m_halt)));
    chk({tag, ".onehot"}, 32'($countones(t_state)), 32'd1);
    chk({tag, ".busdrv"}, 32'($countones({ep, ce, ei, ea, eu}) <= 1), 32'd1);
    chk({tag, ".cp_ep"}, 32'(cp & ep), 32'd0);
    @(posedge clk);
    if (!r) begin
      m_idx = 0;
      m_halt = 1'b0;
    end else if (!m_halt && (!sm || st)) begin
      if (m_idx == 3 && op == 4'hF) m_halt = 1'b1;
      else m_idx = (m_idx + 1) % 6;
    end
    #1;
  endtask

  logic [3:0] ops[5];

  initial begin
    ops[0] = 4'h0; ops[1] = 4'h2; ops[2] = 4'h1; ops[3] = 4'hE; ops[4] = 4'h7;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_idx = 0;
    m_halt = 1'b0;

    // Free-running instructions, one full T1..T6 pass each, plus wrap to T1.
    foreach (ops[k]) for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, ops[k], "run");
    cycle(1'b1, 1'b0, 1'b0, 4'h0, "wrap");

    // HLT: T1..T3 fetch, then T4 halts; steps and step_mode are ignored.
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, 1'b0, 4'hF, "hlt_fetch");
    for (int i = 0; i < 25; i++)
      cycle(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'hF, "hlt_hold");
    cycle(1'b0, 1'b0, 1'b0, 4'hF, "hlt_reset");
    cycle(1'b1, 1'b0, 1'b0, 4'h0, "post_hlt");

    // Single-step: stalled ring holds, a 1-cycle pulse gives one rotation.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 4'h1, "stall");
    cycle(1'b1, 1'b1, 1'b1, 4'h1, "step");
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 4'h1, "stall2");
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1, 4'h1, "step_held");

    // Reset mid-ADD at T5: next cycle back to T1, no T6 accumulator load.
    cycle(1'b0, 1'b0, 1'b0, 4'h1, "sync_rst");
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 4'h1, "add_pre");
    cycle(1'b0, 1'b0, 1'b0, 4'h1, "add_t5_rst");
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 4'h1, "add_after");

    // Random traffic with occasional resets, halts and single-step phases.
    for (int i = 0; i < 600; i++) begin
      logic [3:0] op;
      case ($urandom_range(0, 5))
        0: op = 4'h0;
        1: op = 4'h1;
        2: op = 4'h2;
        3: op = 4'hE;
        4: op = ($urandom_range(0, 3) == 0) ? 4'hF : 4'h0;
        default: op = 4'($urandom_range(0, 15));
      endcase
      cycle(1'($urandom_range(0, 30) != 0), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 1)), op, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
